// File: rtl/mmio_port_pkg.sv
// Register map constants shared by the MMIO port bank and its testbench.
// Offsets are byte offsets inside a channel block or inside the global block.
package mmio_port_pkg;

   localparam logic [31:0] OFF_OUT    = 32'h0;
   localparam logic [31:0] OFF_SET    = 32'h4;
   localparam logic [31:0] OFF_CLR    = 32'h8;
   localparam logic [31:0] OFF_IN     = 32'hC;
   localparam logic [31:0] CH_STRIDE  = 32'h10;
   localparam logic [31:0] OFF_STATUS = 32'h0;
   localparam logic [31:0] OFF_IRQEN  = 32'h4;

   // The global STATUS/IRQ_EN block sits directly after the last channel block.
   function automatic logic [31:0] global_offset(input int nch);
      return CH_STRIDE * 32'(nch);
   endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-stage input synchroniser for a WIDTH-bit bus; o_q is the last stage.
// Async reset clears the whole chain.
module io_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stages;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stages <= '0;
      end else begin
         r_stages <= {r_stages[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stages[STAGES-1];

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of NCH WIDTH-bit I/O channels with atomic set/clear outputs,
// synchronised inputs, sticky change status and a maskable level interrupt.
module mmio_port_bank
   import mmio_port_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               NCH         = 4,
   parameter logic [31:0]      BASE_ADDR   = 32'h800,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          i_addr,
   input  logic [31:0]          i_wdata,
   input  logic                 i_we,
   output logic                 o_hit,
   output logic [31:0]          o_rdata,
   input  logic [NCH*WIDTH-1:0] i_port_in,
   output logic [NCH*WIDTH-1:0] o_port_out,
   output logic                 o_irq
);

   localparam logic [31:0] G   = global_offset(NCH);
   localparam int          CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0][WIDTH-1:0] r_out;
   logic [NCH-1:0][WIDTH-1:0] r_prev;
   logic [NCH-1:0]            r_status;
   logic [NCH-1:0]            r_irqEn;

   logic [NCH-1:0][WIDTH-1:0] w_sync;
   logic [NCH-1:0]            w_change;
   logic [NCH-1:0]            w_w1c;
   logic [31:0]               w_off;
   logic [CHW-1:0]            w_chIdx;
   logic [3:0]                w_regOff;
   logic                      w_inCh;
   logic                      w_wr;
   logic                      w_statusWr;
   logic                      w_irqEnWr;
   logic                      w_unused;

   // Decode: G is a multiple of 16, so the low nibble also selects the global register.
   assign w_off      = i_addr - BASE_ADDR;
   assign o_hit      = (i_addr[1:0] == 2'b00) && (i_addr >= BASE_ADDR) && (w_off < G + 32'd8);
   assign w_inCh     = (w_off < G);
   assign w_chIdx    = w_off[4 +: CHW];
   assign w_regOff   = w_off[3:0];
   assign w_wr       = i_we & o_hit;
   assign w_statusWr = w_wr & ~w_inCh & (w_regOff == OFF_STATUS[3:0]);
   assign w_irqEnWr  = w_wr & ~w_inCh & (w_regOff == OFF_IRQEN[3:0]);
   assign w_w1c      = w_statusWr ? i_wdata[NCH-1:0] : '0;
   assign w_unused   = ^i_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_sync
         io_sync #(
            .WIDTH  (WIDTH),
            .STAGES (SYNC_STAGES)
         ) u_sync (
            .clk   (clk),
            .reset (reset),
            .i_d   (i_port_in[gi*WIDTH +: WIDTH]),
            .o_q   (w_sync[gi])
         );
      end
   endgenerate

   always_comb begin
      w_change = '0;
      for (int i = 0; i < NCH; i++) begin
         w_change[i] = |(w_sync[i] ^ r_prev[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_out[i] <= OUT_RESET;
         end
      end else if (w_wr && w_inCh) begin
         for (int i = 0; i < NCH; i++) begin
            if (w_chIdx == CHW'(i)) begin
               if (w_regOff == OFF_OUT[3:0]) begin
                  r_out[i] <= i_wdata[WIDTH-1:0];
               end else if (w_regOff == OFF_SET[3:0]) begin
                  r_out[i] <= r_out[i] | i_wdata[WIDTH-1:0];
               end else if (w_regOff == OFF_CLR[3:0]) begin
                  r_out[i] <= r_out[i] & ~i_wdata[WIDTH-1:0];
               end
            end
         end
      end
   end

   // A change landing on the same edge as a write-1-to-clear keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev   <= '0;
         r_status <= '0;
         r_irqEn  <= '0;
      end else begin
         r_prev   <= w_sync;
         r_status <= (r_status & ~w_w1c) | w_change;
         if (w_irqEnWr) begin
            r_irqEn <= i_wdata[NCH-1:0];
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      if (o_hit) begin
         if (w_inCh) begin
            for (int i = 0; i < NCH; i++) begin
               if (w_chIdx == CHW'(i)) begin
                  if (w_regOff == OFF_OUT[3:0]) begin
                     o_rdata = 32'(r_out[i]);
                  end else if (w_regOff == OFF_IN[3:0]) begin
                     o_rdata = 32'(w_sync[i]);
                  end
               end
            end
         end else if (w_regOff == OFF_STATUS[3:0]) begin
            o_rdata = 32'(r_status);
         end else begin
            o_rdata = 32'(r_irqEn);
         end
      end
   end

   assign o_port_out = r_out;
   assign o_irq      = |(r_status & r_irqEn);

endmodule
